idma_sync_256b_wr_sched: RTL and testbench

//  Descriptor sequencer in front of the 256b iDMA write channel. Takes one 2D write job
//  (base, row length, row count, row stride), pulses the channel FIFO/cfg inits, then issues
//  wr_req/wr_addr/wr_num commands row by row. Rows longer than MAX_CMD_WORDS are split.

---
 rtl/idma_sync_256b_pkg.sv | 19 +
 rtl/idma_sync_256b_wr_cmd_split.sv | 79 +++++++
 rtl/idma_sync_256b_wr_sched.sv | 155 +++++++++++++++
 tb/tb_idma_sync_256b_wr_sched.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idma_sync_256b_pkg.sv
// Shared types and defaults for the 256b iDMA write-side sequencer.
// Holds the scheduler FSM encoding and the word geometry of the data path.
// Imported by the scheduler top and its command splitter.
package idma_sync_256b_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_INIT  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WAIT  = 3'd4
  } wr_sched_state_e;

  // 256b data word -> 32 bytes of address per word
  localparam int unsigned BYTES_PER_WORD_DEF = 32;
  // longest single command pushed into the channel, in words
  localparam int unsigned MAX_CMD_WORDS_DEF  = 256;

endpackage

// File: rtl/idma_sync_256b_wr_cmd_split.sv
// Purpose: walks a 2D job row by row and presents the next command (addr, num, last).
// Latency: command registers update one cycle after load/adv; outputs are registered.
// Backpressure: advances only on adv (an accepted wr_req); otherwise holds the command.
module idma_sync_256b_wr_cmd_split
  import idma_sync_256b_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WID   = 32,
  parameter int unsigned BYTES_PER_WORD = BYTES_PER_WORD_DEF,
  parameter int unsigned MAX_CMD_WORDS  = MAX_CMD_WORDS_DEF
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    load,
  input  logic                    adv,
  input  logic [AXI_ADDR_WID-1:0] base_addr,
  input  logic [15:0]             row_words,
  input  logic [15:0]             row_num,
  input  logic [AXI_ADDR_WID-1:0] row_stride,
  output logic [AXI_ADDR_WID-1:0] cmd_addr,
  output logic [31:0]             cmd_num,
  output logic                    cmd_last
);

  localparam logic [16:0]             MAXW  = 17'(MAX_CMD_WORDS);
  localparam logic [AXI_ADDR_WID-1:0] BPW_A = AXI_ADDR_WID'(BYTES_PER_WORD);

  function automatic logic [16:0] chunk(input logic [16:0] words);
    return (words > MAXW) ? MAXW : words;
  endfunction

  logic [AXI_ADDR_WID-1:0] cur_addr;
  logic [AXI_ADDR_WID-1:0] row_ptr;
  logic [16:0]             cur_num;
  logic [15:0]             rem_q;      // words of the current row still unissued after cur_num
  logic [15:0]             rows_left;  // rows after the current one
  logic [16:0]             first_num;
  logic [16:0]             next_num;
  logic [AXI_ADDR_WID-1:0] step;
  logic [AXI_ADDR_WID-1:0] next_row;

  assign first_num = chunk({1'b0, row_words});
  assign next_num  = chunk({1'b0, rem_q});
  assign step      = AXI_ADDR_WID'(cur_num) * BPW_A;
  assign next_row  = row_ptr + row_stride;

  // Load the first chunk of row 0, then step within a row or jump to the next row start
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cur_addr  <= '0;
      row_ptr   <= '0;
      cur_num   <= '0;
      rem_q     <= '0;
      rows_left <= '0;
    end else if (load) begin
      cur_addr  <= base_addr;
      row_ptr   <= base_addr;
      cur_num   <= first_num;
      rem_q     <= row_words - first_num[15:0];
      rows_left <= row_num - 16'd1;
    end else if (adv && !cmd_last) begin
      if (rem_q == 16'd0) begin
        cur_addr  <= next_row;
        row_ptr   <= next_row;
        cur_num   <= first_num;
        rem_q     <= row_words - first_num[15:0];
        rows_left <= rows_left - 16'd1;
      end else begin
        cur_addr  <= cur_addr + step;
        cur_num   <= next_num;
        rem_q     <= rem_q - next_num[15:0];
      end
    end
  end

  assign cmd_addr = cur_addr;
  assign cmd_num  = {15'd0, cur_num};
  assign cmd_last = (rem_q == 16'd0) && (rows_left == 16'd0);

endmodule

// File: rtl/idma_sync_256b_wr_sched.sv
// Purpose: sequences one 2D write job into the 256b iDMA write channel (init, cmds, done).
// Latency: start -> check -> init pulse -> first wr_req; done when all beats + write_all_done.
// Backpressure: wr_req only while wr_addr_ready; optional WAIT watchdog via IDMA_WR_SCHED_TIMEOUT_EN.
module idma_sync_256b_wr_sched
  import idma_sync_256b_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WID   = 32,
  parameter int unsigned BYTES_PER_WORD = BYTES_PER_WORD_DEF,
  parameter int unsigned MAX_CMD_WORDS  = MAX_CMD_WORDS_DEF,
  parameter int unsigned CNT_WID        = 32,
  parameter int unsigned TIMEOUT_CYC    = 4096
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [AXI_ADDR_WID-1:0] cfg_base_addr,
  input  logic [15:0]             cfg_row_words,
  input  logic [15:0]             cfg_row_num,
  input  logic [AXI_ADDR_WID-1:0] cfg_row_stride,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    wr_afifo_init,
  output logic                    wr_dfifo_init,
  output logic                    wr_cfg_init,
  output logic                    wr_req,
  output logic [AXI_ADDR_WID-1:0] wr_addr,
  output logic [31:0]             wr_num,
  input  logic                    wr_addr_ready,
  input  logic                    wr_data_valid,
  input  logic                    wr_data_ready,
  input  logic                    write_all_done
);

  wr_sched_state_e         state_q, state_d;
  logic [AXI_ADDR_WID-1:0] base_q, stride_q;
  logic [15:0]             rw_q, rn_q;
  logic                    flush_q, flush_d;  // channel re-init after abort/timeout
  logic [CNT_WID-1:0]      beat_cnt;
  logic [31:0]             total;
  logic                    beat, bad_cfg, beats_met, done_cond, timeout_hit, cmd_last;

  assign beat      = wr_data_valid & wr_data_ready;
  assign bad_cfg   = (rw_q == 16'd0) || (rn_q == 16'd0);
  assign total     = {16'd0, rw_q} * {16'd0, rn_q};
  assign beats_met = (beat_cnt == CNT_WID'(total));
  assign done_cond = (state_q == ST_WAIT) && beats_met && write_all_done && !abort;

  // Capture the job description once, when a job is accepted
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      base_q   <= '0;
      stride_q <= '0;
      rw_q     <= '0;
      rn_q     <= '0;
    end else if ((state_q == ST_IDLE) && start) begin
      base_q   <= cfg_base_addr;
      stride_q <= cfg_row_stride;
      rw_q     <= cfg_row_words;
      rn_q     <= cfg_row_num;
    end
  end

  // State register plus the one-cycle flush request
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= ST_IDLE;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
    end
  end

  // Next state; abort from any busy state and a watchdog expiry both flush back to IDLE
  always_comb begin
    state_d = state_q;
    flush_d = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_CHECK;
      ST_CHECK: state_d = bad_cfg ? ST_IDLE : ST_INIT;
      ST_INIT:  state_d = ST_ISSUE;
      ST_ISSUE: if (wr_req && cmd_last) state_d = ST_WAIT;
      ST_WAIT:  if (done_cond || timeout_hit) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if ((state_q != ST_IDLE) && abort) begin
      state_d = ST_IDLE;
      flush_d = 1'b1;
    end
    if (timeout_hit) flush_d = 1'b1;
  end

  // Outputs; the channel pushes wr_req unconditionally so it is gated by ready here
  always_comb begin
    busy          = (state_q != ST_IDLE);
    wr_req        = (state_q == ST_ISSUE) && wr_addr_ready && !abort;
    wr_afifo_init = (state_q == ST_INIT) || flush_q;
    wr_dfifo_init = (state_q == ST_INIT) || flush_q;
    wr_cfg_init   = (state_q == ST_INIT) || flush_q;
    done          = done_cond;
    err           = ((state_q == ST_CHECK) && bad_cfg && !abort) || timeout_hit;
  end

  // Count accepted data beats from the first ISSUE cycle; surplus beats are dropped
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      beat_cnt <= '0;
    end else if ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) begin
      if (beat && !beats_met) beat_cnt <= beat_cnt + CNT_WID'(1);
    end else begin
      beat_cnt <= '0;
    end
  end

`ifdef IDMA_WR_SCHED_TIMEOUT_EN
  logic [31:0] wd_cnt;

  // Idle cycles spent in WAIT since entry or since the last accepted beat
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wd_cnt <= '0;
    end else if ((state_q != ST_WAIT) || beat) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 32'd1;
    end
  end

  assign timeout_hit = (state_q == ST_WAIT) && !abort && !done_cond && !beat &&
                       (wd_cnt == 32'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  idma_sync_256b_wr_cmd_split #(
    .AXI_ADDR_WID   (AXI_ADDR_WID),
    .BYTES_PER_WORD (BYTES_PER_WORD),
    .MAX_CMD_WORDS  (MAX_CMD_WORDS)
  ) u_split (
    .aclk       (aclk),
    .areset     (areset),
    .load       (state_q == ST_CHECK),
    .adv        (wr_req),
    .base_addr  (base_q),
    .row_words  (rw_q),
    .row_num    (rn_q),
    .row_stride (stride_q),
    .cmd_addr   (wr_addr),
    .cmd_num    (wr_num),
    .cmd_last   (cmd_last)
  );

endmodule

// File: tb/tb_idma_sync_256b_wr_sched.sv
module tb_idma_sync_256b_wr_sched;

  logic        aclk = 1'b0;
  logic        areset, start, abort;
  logic [31:0] cfg_base_addr, cfg_row_stride;
  logic [15:0] cfg_row_words, cfg_row_num;
  logic        busy, done, err, wr_afifo_init, wr_dfifo_init, wr_cfg_init, wr_req;
  logic [31:0] wr_addr, wr_num;
  logic        wr_addr_ready, wr_data_valid, wr_data_ready, write_all_done;

  always #5 aclk = ~aclk;

  idma_sync_256b_wr_sched #(.TIMEOUT_CYC(16)) dut (
    .aclk(aclk), .areset(areset), .start(start), .abort(abort),
    .cfg_base_addr(cfg_base_addr), .cfg_row_words(cfg_row_words),
    .cfg_row_num(cfg_row_num), .cfg_row_stride(cfg_row_stride),
    .busy(busy), .done(done), .err(err),
    .wr_afifo_init(wr_afifo_init), .wr_dfifo_init(wr_dfifo_init), .wr_cfg_init(wr_cfg_init),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_num(wr_num),
    .wr_addr_ready(wr_addr_ready), .wr_data_valid(wr_data_valid),
    .wr_data_ready(wr_data_ready), .write_all_done(write_all_done)
  );

  int n_vec = 0;
  int n_mis = 0;
  int cyc   = 0;

  bit          beat_log [32768];
  bit          wad_log  [32768];
  bit          busy_log [32768];
  logic [31:0] cmd_addr_q [$];
  int          cmd_num_q  [$];
  int          cmd_cyc_q  [$];
  int          init_cyc_q [$];
  int          done_cyc_q [$];
  int          err_cyc_q  [$];
  int          rdy_viol   = 0;
  int          init_viol  = 0;

  function automatic int ix(input int c);
    return c & 32767;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_logs();
    cmd_addr_q.delete(); cmd_num_q.delete(); cmd_cyc_q.delete();
    init_cyc_q.delete(); done_cyc_q.delete(); err_cyc_q.delete();
    rdy_viol  = 0;
    init_viol = 0;
  endtask

  task automatic idle_inputs();
    start = 0; abort = 0; wr_addr_ready = 0;
    wr_data_valid = 0; wr_data_ready = 0; write_all_done = 0;
  endtask

  // Observer: logs every cycle mid-period, away from the active edge
  initial begin
    forever begin
      @(negedge aclk);
      cyc++;
      beat_log[ix(cyc)] = wr_data_valid & wr_data_ready;
      wad_log[ix(cyc)]  = write_all_done;
      busy_log[ix(cyc)] = busy;
      if (wr_req === 1'b1) begin
        cmd_addr_q.push_back(wr_addr);
        cmd_num_q.push_back(int'(wr_num));
        cmd_cyc_q.push_back(cyc);
        if (wr_addr_ready !== 1'b1) rdy_viol++;
      end
      if ((wr_afifo_init | wr_dfifo_init | wr_cfg_init) === 1'b1) begin
        init_cyc_q.push_back(cyc);
        if (!(wr_afifo_init && wr_dfifo_init && wr_cfg_init)) init_viol++;
      end
      if (done === 1'b1) done_cyc_q.push_back(cyc);
      if (err === 1'b1)  err_cyc_q.push_back(cyc);
    end
  end

  // One complete job against the reference: command list from the row/chunk rules,
  // done on the first WAIT cycle where all required beats were taken and write_all_done is high
  task automatic run_job(input string nm, input logic [31:0] base, input logic [15:0] rw,
                         input logic [15:0] rn, input logic [31:0] stride, input int rdy_mode,
                         input int wad_thr, input bit glitch, input bit abort_at_start);
    logic [31:0] ea [$];
    int          en [$];
    logic [31:0] a;
    int          rem, n, total, beats, budget, exp_done, cnt, last_cmd, dc;
    bit          v, r;
    for (int row = 0; row < int'(rn); row++) begin
      a   = base + 32'(row) * stride;
      rem = int'(rw);
      while (rem > 0) begin
        n = (rem > 256) ? 256 : rem;
        ea.push_back(a);
        en.push_back(n);
        a   = a + 32'(n * 32);
        rem = rem - n;
      end
    end
    total = int'(rw) * int'(rn);
    beats = 0;
    clear_logs();
    cfg_base_addr = base; cfg_row_words = rw; cfg_row_num = rn; cfg_row_stride = stride;
    start = 1; abort = abort_at_start;
    step();
    start = 0; abort = 0;
    budget = 4 * total + 64 + 4 * ea.size();
    for (int k = 0; k < budget && done_cyc_q.size() == 0 && err_cyc_q.size() == 0; k++) begin
      case (rdy_mode)
        0:       wr_addr_ready = 1'b1;
        1:       wr_addr_ready = (k % 2 == 0);
        default: wr_addr_ready = 1'($urandom_range(0, 1));
      endcase
      v = (init_cyc_q.size() > 0) && ($urandom_range(0, 3) != 0);
      r = (init_cyc_q.size() > 0) && ($urandom_range(0, 3) != 0);
      wr_data_valid  = v;
      wr_data_ready  = r;
      write_all_done = (beats >= wad_thr);
      if (v && r) beats++;
      if (glitch && k == 3) begin
        start = 1; cfg_base_addr = 32'hdead_0000; cfg_row_words = 16'd1;
      end else begin
        start = 0; cfg_base_addr = base; cfg_row_words = rw;
      end
      step();
    end
    idle_inputs();
    step();
    chk({nm, " done_count"}, done_cyc_q.size(), 1);
    chk({nm, " err_count"}, err_cyc_q.size(), 0);
    chk({nm, " init_count"}, init_cyc_q.size(), 1);
    chk({nm, " init_all_three"}, init_viol, 0);
    chk({nm, " req_without_ready"}, rdy_viol, 0);
    chk({nm, " cmd_count"}, cmd_addr_q.size(), ea.size());
    for (int i = 0; i < ea.size() && i < cmd_addr_q.size(); i++) begin
      chk($sformatf("%s cmd%0d_addr", nm, i), cmd_addr_q[i], ea[i]);
      chk($sformatf("%s cmd%0d_num", nm, i), cmd_num_q[i], en[i]);
    end
    if (init_cyc_q.size() > 0 && cmd_cyc_q.size() > 0 && done_cyc_q.size() > 0) begin
      chk({nm, " first_cmd_after_init"}, cmd_cyc_q[0] > init_cyc_q[0], 1);
      last_cmd = cmd_cyc_q[cmd_cyc_q.size() - 1];
      dc       = done_cyc_q[0];
      exp_done = -1;
      cnt      = 0;
      for (int c = init_cyc_q[0] + 1; c <= cyc; c++) begin
        if (c > last_cmd && cnt >= total && wad_log[ix(c)]) begin
          exp_done = c;
          break;
        end
        if (beat_log[ix(c)]) cnt++;
      end
      chk({nm, " done_cycle"}, dc, exp_done);
      chk({nm, " busy_in_job"}, busy_log[ix(init_cyc_q[0])], 1);
      chk({nm, " busy_after_done"}, busy_log[ix(dc + 1)], 0);
    end
  endtask

  initial begin
    int          s0, ab, last_cmd, after, ec;
    logic [15:0] rw_r, rn_r;

    areset = 1;
    idle_inputs();
    cfg_base_addr = 0; cfg_row_words = 0; cfg_row_num = 0; cfg_row_stride = 0;
    repeat (2) @(posedge aclk);
    #1;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    chk("rst afifo_init", wr_afifo_init, 0);
    chk("rst dfifo_init", wr_dfifo_init, 0);
    chk("rst cfg_init", wr_cfg_init, 0);
    chk("rst wr_req", wr_req, 0);
    chk("rst wr_addr", wr_addr, 0);
    chk("rst wr_num", wr_num, 0);
    areset = 0;
    step();

    // single short row
    run_job("t1", 32'h1000, 16'd8, 16'd1, 32'h0, 0, 8, 1'b0, 1'b0);
    // long row split into 256/256/88, plus a start pulse while busy
    run_job("t2", 32'h0, 16'd600, 16'd1, 32'h0, 2, 600, 1'b1, 1'b0);
    // three rows, write_all_done early; abort together with start in IDLE
    run_job("t3", 32'h0, 16'd4, 16'd3, 32'h400, 0, 8, 1'b0, 1'b1);
    // ready toggling 1010 during ISSUE
    run_job("t4", 32'h0, 16'd600, 16'd1, 32'h0, 1, 0, 1'b0, 1'b0);

    // bad configurations: zero rows, zero words
    for (int b = 0; b < 2; b++) begin
      clear_logs();
      cfg_base_addr = 32'h40; cfg_row_stride = 32'h100;
      cfg_row_words = (b == 0) ? 16'd5 : 16'd0;
      cfg_row_num   = (b == 0) ? 16'd0 : 16'd2;
      start = 1; wr_addr_ready = 1;
      step();
      s0 = cyc;
      start = 0;
      repeat (4) step();
      wr_addr_ready = 0;
      chk($sformatf("bad%0d err_count", b), err_cyc_q.size(), 1);
      chk($sformatf("bad%0d err_cycle", b), err_cyc_q.size() > 0 ? err_cyc_q[0] : -1, s0 + 1);
      chk($sformatf("bad%0d init_count", b), init_cyc_q.size(), 0);
      chk($sformatf("bad%0d cmd_count", b), cmd_addr_q.size(), 0);
      chk($sformatf("bad%0d busy_after", b), busy_log[ix(s0 + 2)], 0);
    end

    // abort in the middle of ISSUE
    clear_logs();
    cfg_base_addr = 32'h0; cfg_row_words = 16'd600; cfg_row_num = 16'd2; cfg_row_stride = 32'h8000;
    start = 1;
    step();
    start = 0;
    for (int k = 0; k < 20 && cmd_addr_q.size() < 2; k++) begin
      wr_addr_ready = 1;
      step();
    end
    chk("abort reached_issue", cmd_addr_q.size() >= 2, 1);
    abort = 1;
    step();
    ab = cyc;
    abort = 0;
    repeat (3) step();
    wr_addr_ready = 0;
    after = 0;
    foreach (cmd_cyc_q[i]) if (cmd_cyc_q[i] > ab) after++;
    chk("abort init_count", init_cyc_q.size(), 2);
    chk("abort init_cycle", init_cyc_q.size() > 1 ? init_cyc_q[1] : -1, ab + 1);
    chk("abort init_all_three", init_viol, 0);
    chk("abort busy_next", busy_log[ix(ab + 1)], 0);
    chk("abort cmds_after", after, 0);
    chk("abort done_count", done_cyc_q.size(), 0);
    chk("abort err_count", err_cyc_q.size(), 0);

    // abort while IDLE does nothing
    clear_logs();
    abort = 1;
    step();
    abort = 0;
    repeat (2) step();
    chk("idle_abort init_count", init_cyc_q.size(), 0);
    chk("idle_abort busy", busy_log[ix(cyc)], 0);

    // data stalled in WAIT
    clear_logs();
    cfg_base_addr = 32'h2000; cfg_row_words = 16'd4; cfg_row_num = 16'd1; cfg_row_stride = 32'h0;
    start = 1;
    step();
    start = 0;
    for (int k = 0; k < 60 && err_cyc_q.size() == 0; k++) begin
      wr_addr_ready = 1;
      step();
    end
    wr_addr_ready = 0;
    step();
    last_cmd = cmd_cyc_q.size() > 0 ? cmd_cyc_q[cmd_cyc_q.size() - 1] : -1;
    chk("stall cmd_count", cmd_addr_q.size(), 1);
`ifdef IDMA_WR_SCHED_TIMEOUT_EN
    ec = err_cyc_q.size() > 0 ? err_cyc_q[0] : -1;
    chk("tmo err_count", err_cyc_q.size(), 1);
    chk("tmo err_cycle", ec, last_cmd + 16);
    chk("tmo busy_next", busy_log[ix(ec + 1)], 0);
    chk("tmo init_cycle", init_cyc_q.size() > 1 ? init_cyc_q[1] : -1, ec + 1);
    chk("tmo done_count", done_cyc_q.size(), 0);
`else
    chk("stall err_count", err_cyc_q.size(), 0);
    chk("stall still_busy", busy_log[ix(cyc)], 1);
    ec = 0;
    for (int k = 0; k < 40 && done_cyc_q.size() == 0; k++) begin
      wr_data_valid = (ec < 4); wr_data_ready = (ec < 4);
      write_all_done = (ec >= 4);
      if (ec < 4) ec++;
      step();
    end
    idle_inputs();
    step();
    chk("stall done_count", done_cyc_q.size(), 1);
    chk("stall last_cmd_before_done", done_cyc_q.size() > 0 ? done_cyc_q[0] > last_cmd + 40 : 0, 1);
`endif

    // randomized jobs, including address wrap near the top of the space
    for (int j = 0; j < 3; j++) begin
      rw_r = 16'($urandom_range(1, 300));
      rn_r = 16'($urandom_range(1, 3));
      run_job($sformatf("rnd%0d", j), $urandom & 32'hffff_ffe0, rw_r, rn_r,
              $urandom & 32'h000f_ffe0, 2, $urandom_range(0, int'(rw_r) * int'(rn_r)),
              1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL global_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
